onehot_encoder_2bit: RTL
========================

Name: onehot_encoder_2bit

Overview:
Sequential encoder for four one-hot select lines (board buttons or switches) into a 2-bit index. It is the inverse of the 2-bit one-hot decoder used elsewhere in the readout path. Inputs are synchronised and debounced, then encoded with highest-bit priority. The index is presented to the readout control logic through a valid/ready handshake, and the block counts accepted selections.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a press or a release; legal range 1..2^CNT_W-1; 0 is illegal.
CNT_W, 8, width of the debounce counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
resetN  input  1  asynchronous, active-low reset.
signalIn  input  4  raw, asynchronous select lines; bit n asserted selects index n.
ready  input  1  consumer accepts indexOut while valid is high.
indexOut  output  2  encoded index of the highest set bit of the accepted pattern.
valid  output  1  indexOut and multiHot are held and stable.
multiHot  output  1  accepted pattern had more than one bit set.
acceptCount  output  8  number of completed handshakes, modulo 256.

Behaviour:
- Reset (resetN low, asynchronous):
  - Both synchroniser stages go to 0; the FSM goes to IDLE.
  - Debounce counter and captured sample go to 0.
  - indexOut=0, valid=0, multiHot=0, acceptCount=0.
  - Assertion mid-operation aborts immediately: no handshake is completed and the count is not incremented.
- Synchroniser: two-flop chain on signalIn. "synced" means the second stage. All FSM decisions use synced only.
- IDLE:
  - synced==0: stay.
  - synced!=0: capture sample=synced, counter=0, go to DEBOUNCE.
- DEBOUNCE:
  - synced==0: go to IDLE.
  - synced!=sample (nonzero): recapture sample=synced, counter=0, stay.
  - synced==sample with counter==DEBOUNCE_CYCLES-1: load indexOut=priority(sample) and multiHot=(popcount(sample)>1), set valid=1, go to HOLD.
  - synced==sample otherwise: counter+1.
- Priority encoding: bit3→3, bit2→2, bit1→1, bit0→0. Examples: 4'b0110→2, 4'b1001→3.
- HOLD:
  - valid=1; indexOut and multiHot are frozen.
  - signalIn activity is ignored.
  - ready=1 at a rising edge: valid=0 on that edge, acceptCount+1 (255 wraps to 0), counter=0, go to RELEASE.
  - ready may be held high permanently; the handshake then completes on the first cycle valid is high.
- RELEASE:
  - Waits for debounced release, so a single long press produces exactly one event.
  - synced!=0: counter=0, stay.
  - synced==0 with counter==DEBOUNCE_CYCLES-1: go to IDLE.
  - synced==0 otherwise: counter+1.
  - indexOut and multiHot keep their last values; valid=0.
- Latency: signalIn stable from before clock edge 1 gives valid high after edge DEBOUNCE_CYCLES+3. For DEBOUNCE_CYCLES=4, that is edge 7.
- Minimum re-arm after acceptance: DEBOUNCE_CYCLES cycles of synced==0, plus the IDLE entry.
- Glitches:
  - A nonzero pulse shorter than DEBOUNCE_CYCLES synced cycles never raises valid.
  - A release glitch during RELEASE restarts the release count.
- valid never drops without ready, except on reset.
- No combinational path from any input to any output; all outputs are registered.
- Unreachable FSM encodings recover to IDLE on the next edge.

Test Plan:
- DEBOUNCE_CYCLES=4, reset released, signalIn=4'b0100 held → valid rises after edge 7, indexOut=2, multiHot=0. ready pulse → valid=0 on the next edge, acceptCount=1.
- signalIn=4'b1010 held, ready tied high → indexOut=3, multiHot=1. valid is high for exactly one cycle, acceptCount increments once even though the input is held 50 cycles.
- signalIn=4'b0001 for 3 synced cycles, then 0 → valid never asserts, FSM returns to IDLE, acceptCount unchanged.
- In RELEASE, signalIn toggles 0→1→0 with 2-cycle pulses → no IDLE entry until 4 consecutive zero cycles. A following 4'b0010 press yields indexOut=1.
- resetN asserted low while in HOLD with valid=1 → valid, indexOut, multiHot and acceptCount read 0 immediately, without waiting for a clock edge. After release, a new press produces a normal event.
- 256 press/accept cycles → acceptCount wraps to 0 on the 256th handshake. The 257th gives 1.

Source files
------------

// File: rtl/onehot_encoder_2bit.sv
// Synchronises and debounces four select lines, priority-encodes the accepted
// pattern into a 2-bit index and hands it out over a valid/ready handshake.

module onehot_encoder_2bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] signalIn,
    input  logic       ready,
    output logic [1:0] indexOut,
    output logic       valid,
    output logic       multiHot,
    output logic [7:0] acceptCount
);

    // state    | meaning
    // IDLE     | no selection seen, waiting for a nonzero pattern
    // DEBOUNCE | pattern captured, counting stable cycles
    // HOLD     | index presented, waiting for ready
    // RELEASE  | accepted, waiting for a debounced all-zero release
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Down-counter: loaded with the last count, terminal at zero.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_nx;
    logic [3:0]       sync1, synced;
    logic [3:0]       sample, sample_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       index_nx;
    logic             valid_nx;
    logic             multi_nx;
    logic [7:0]       count_nx;

    function automatic logic [1:0] prio_enc(input logic [3:0] s);
        logic [1:0] r;
        if (s[3])      r = 2'd3;
        else if (s[2]) r = 2'd2;
        else if (s[1]) r = 2'd1;
        else           r = 2'd0;
        return r;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1  <= '0;
            synced <= '0;
        end else begin
            sync1  <= signalIn;
            synced <= sync1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            sample      <= '0;
            cnt         <= '0;
            indexOut    <= '0;
            valid       <= 1'b0;
            multiHot    <= 1'b0;
            acceptCount <= '0;
        end else begin
            state       <= state_nx;
            sample      <= sample_nx;
            cnt         <= cnt_nx;
            indexOut    <= index_nx;
            valid       <= valid_nx;
            multiHot    <= multi_nx;
            acceptCount <= count_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sample_nx = sample;
        cnt_nx    = cnt;
        index_nx  = indexOut;
        valid_nx  = valid;
        multi_nx  = multiHot;
        count_nx  = acceptCount;

        case (state)
            IDLE: begin
                valid_nx = 1'b0;
                if (synced != 4'b0) begin
                    sample_nx = synced;
                    cnt_nx    = CNT_LAST;
                    state_nx  = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                valid_nx = 1'b0;
                if (synced == 4'b0) begin
                    state_nx = IDLE;
                end else if (synced != sample) begin
                    sample_nx = synced;
                    cnt_nx    = CNT_LAST;
                end else if (cnt == '0) begin
                    index_nx = prio_enc(sample);
                    multi_nx = ((sample & (sample - 4'd1)) != 4'b0);
                    valid_nx = 1'b1;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            HOLD: begin
                valid_nx = 1'b1;
                if (ready) begin
                    valid_nx = 1'b0;
                    count_nx = acceptCount + 8'd1;
                    cnt_nx   = CNT_LAST;
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                valid_nx = 1'b0;
                if (synced != 4'b0) begin
                    cnt_nx = CNT_LAST;
                end else if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                valid_nx = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule
